dco_ctr: RTL and testbench
==========================

Name: dco_ctr

Overview:
- Synthesizable digital front-end that drives the DCO tuning interface.
- Converts binary tuning words for the large (L), medium (M) and small (S) capacitor banks into the row/column/row-all select codes the DCO capacitor arrays decode.
- Sequences DCO power-up and applies each new tuning word bank by bank (L, then M, then S) through a valid/ready handshake.
- Sits between the ADPLL loop filter/normalization and the DCO.

Parameters:
PWRUP_CYCLES, 16, cycles pd is held low before first tuning word is accepted (>=1)
STARTUP_GAIN, 2'b11, osc_gain driven during power-up
INIT_L, 12, L code applied on reset/OFF (0..25)
INIT_M, 128, M code applied on reset/OFF (0..255)
INIT_S, 128, S code applied on reset/OFF (0..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  DCO enable; 0 forces OFF
tune_l  in  5  L bank code, valid 0..25
tune_m  in  8  M bank code
tune_s  in  8  S bank code
gain_in  in  2  oscillator gain for this word
tune_valid  in  1  tuning word valid
tune_ready  out  1  controller can accept word
pd  out  1  DCO power-down
osc_gain  out  2  DCO gain
c_l_rall, c_l_row, c_l_col  out  5 each  L select codes
c_m_rall, c_m_row, c_m_col  out  16 each  M select codes
c_s_rall, c_s_row, c_s_col  out  16 each  S select codes
upd_done  out  1  one-cycle pulse when S bank applied
l_sat  out  1  last accepted tune_l exceeded 25

Behaviour:
- Encoding, bank size N (5 for L, 16 for M/S), code v: q=v/N, r=v%N. rall[i]=1 for i<q; row[i]=1 for i==q (no bit when q==N); col[j]=1 for j<r.
- Cell count = N*q+r = v. Examples: M 128 -> rall=0x00FF, row=0x0100, col=0. M 255 -> rall=0x7FFF, row=0x8000, col=0x7FFF. L 25 -> rall=5'h1F, row=0, col=0.
- L saturation: tune_l>25 is clamped to 25 at capture and sets l_sat. Otherwise l_sat is cleared at capture.
- All outputs are registered. Encoders act on registered codes.
- Reset (rst_n=0, async): state OFF, pd=1, osc_gain=0, tune_ready=0, upd_done=0, l_sat=0. Bank outputs encode INIT_L/INIT_M/INIT_S.
- States:
  - OFF: pd=1, ready=0. en=1 -> PWRUP with counter loaded to PWRUP_CYCLES-1.
  - PWRUP: pd=0, osc_gain=STARTUP_GAIN, ready=0. Counter decrements each cycle; at 0 -> IDLE.
  - IDLE: ready=1. tune_valid&tune_ready at edge k captures tune_l(clamped)/m/s/gain_in -> UPD_L.
  - UPD_L: L outputs and osc_gain take the new value at edge k+1 -> UPD_M.
  - UPD_M: M outputs update at edge k+2 -> UPD_S.
  - UPD_S: S outputs update at edge k+3; upd_done=1 for the following cycle -> IDLE.
- Timing: tune_ready is low from the cycle after capture until after edge k+3, then high again. Back-to-back words are therefore spaced 4 cycles apart minimum.
- tune_valid while ready=0 is ignored (not queued). Input words need only be stable on the handshake edge.
- en=0 in any state: next edge -> OFF. pd=1, osc_gain=0, banks reload INIT codes, any in-flight update is abandoned, no upd_done.
- en toggled during PWRUP restarts power-up from OFF.
- Async reset mid-update: immediate return to reset values.
- Bank update order is fixed L->M->S; only one bank changes per edge.

Test Plan:
- Reset, en=1 -> pd falls the edge after en; tune_ready rises exactly PWRUP_CYCLES=16 cycles later. Bank outputs stay at INIT (M: rall=0x00FF, row=0x0100, col=0) throughout.
- Handshake L=7, M=0x5A, S=0xFF, gain=2 -> L rall=5'h01, row=5'h02, col=5'h03 at k+1 with osc_gain=2. M rall=0x001F, row=0x0020, col=0x03FF at k+2. S rall=0x7FFF, row=0x8000, col=0x7FFF at k+3. upd_done pulses once; ready returns.
- tune_l=31 -> L outputs encode 25 (rall=5'h1F, row=0, col=0), l_sat=1. Next word with tune_l=3 clears l_sat.
- tune_valid held high continuously with changing words -> captures only on ready cycles, spaced 4 cycles apart. Intermediate words are dropped.
- en dropped in UPD_M -> next edge pd=1, osc_gain=0, all banks at INIT, no upd_done, tune_ready=0.
- Sweep M and S codes 0..255 and L codes 0..25; checker counts rall|(row&col) cells -> count equals applied code for every value.

Source files
------------

// File: rtl/dco_ctr.sv
// DCO tuning front-end: power-up sequencing and bank-by-bank (L->M->S) thermometer/row-column encoding.
// Latency: L at k+1, M at k+2, S at k+3 after handshake edge k; upd_done the cycle after; one word per 4 cycles max.
module dco_ctr #(
   parameter int          PWRUP_CYCLES = 16,
   parameter logic [1:0]  STARTUP_GAIN = 2'b11,
   parameter int          INIT_L       = 12,
   parameter int          INIT_M       = 128,
   parameter int          INIT_S       = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [4:0]  tune_l,
   input  logic [7:0]  tune_m,
   input  logic [7:0]  tune_s,
   input  logic [1:0]  gain_in,
   input  logic        tune_valid,
   output logic        tune_ready,
   output logic        pd,
   output logic [1:0]  osc_gain,
   output logic [4:0]  c_l_rall,
   output logic [4:0]  c_l_row,
   output logic [4:0]  c_l_col,
   output logic [15:0] c_m_rall,
   output logic [15:0] c_m_row,
   output logic [15:0] c_m_col,
   output logic [15:0] c_s_rall,
   output logic [15:0] c_s_row,
   output logic [15:0] c_s_col,
   output logic        upd_done,
   output logic        l_sat
);

   localparam int CW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;

   typedef enum logic [2:0] {OFF, PWRUP, IDLE, UPD_L, UPD_M, UPD_S} state_t;

   typedef struct packed {
      logic [4:0] rall;
      logic [4:0] row;
      logic [4:0] col;
   } sel5_t;

   typedef struct packed {
      logic [15:0] rall;
      logic [15:0] row;
      logic [15:0] col;
   } sel16_t;

   // Row/column split: q full rows, one partial row enabled on r columns.
   function automatic sel5_t enc5(input logic [4:0] v);
      logic [4:0] q;
      logic [4:0] r;
      sel5_t      e;
      q = v / 5'd5;
      r = v % 5'd5;
      for (int i = 0; i < 5; i++) begin
         e.rall[i] = (5'(i) < q);
         e.row[i]  = (5'(i) == q);
         e.col[i]  = (5'(i) < r);
      end
      return e;
   endfunction

   function automatic sel16_t enc16(input logic [7:0] v);
      sel16_t e;
      for (int i = 0; i < 16; i++) begin
         e.rall[i] = (4'(i) < v[7:4]);
         e.row[i]  = (4'(i) == v[7:4]);
         e.col[i]  = (4'(i) < v[3:0]);
      end
      return e;
   endfunction

   localparam sel5_t  L_INIT = enc5(5'(INIT_L));
   localparam sel16_t M_INIT = enc16(8'(INIT_M));
   localparam sel16_t S_INIT = enc16(8'(INIT_S));

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;

   logic [4:0]      cap_l, cap_l_d;
   logic [7:0]      cap_m, cap_m_d;
   logic [7:0]      cap_s, cap_s_d;
   logic [1:0]      cap_gain, cap_gain_d;
   sel5_t           l_q, l_d;
   sel16_t          m_q, m_d;
   sel16_t          s_q, s_d;
   logic            pd_q, pd_d;
   logic [1:0]      gain_q, gain_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            lsat_q, lsat_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OFF;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!en) begin
         state_nxt = OFF;
      end else begin
         case (state)
            OFF: begin
               state_nxt = PWRUP;
               cnt_nxt   = CW'(PWRUP_CYCLES - 1);
            end
            PWRUP: begin
               if (cnt == '0) state_nxt = IDLE;
               else           cnt_nxt   = cnt - 1'b1;
            end
            IDLE:    if (tune_valid) state_nxt = UPD_L;
            UPD_L:   state_nxt = UPD_M;
            UPD_M:   state_nxt = UPD_S;
            UPD_S:   state_nxt = IDLE;
            default: state_nxt = OFF;
         endcase
      end
   end

   // Next values of every registered output; a dropped enable overrides any state.
   always_comb begin
      cap_l_d    = cap_l;
      cap_m_d    = cap_m;
      cap_s_d    = cap_s;
      cap_gain_d = cap_gain;
      l_d        = l_q;
      m_d        = m_q;
      s_d        = s_q;
      pd_d       = pd_q;
      gain_d     = gain_q;
      ready_d    = 1'b0;
      done_d     = 1'b0;
      lsat_d     = lsat_q;
      if (!en) begin
         pd_d   = 1'b1;
         gain_d = 2'b00;
         l_d    = L_INIT;
         m_d    = M_INIT;
         s_d    = S_INIT;
      end else begin
         case (state)
            OFF: begin
               pd_d   = 1'b0;
               gain_d = STARTUP_GAIN;
            end
            PWRUP:   ready_d = (cnt == '0);
            IDLE: begin
               if (tune_valid) begin
                  lsat_d     = (tune_l > 5'd25);
                  cap_l_d    = (tune_l > 5'd25) ? 5'd25 : tune_l;
                  cap_m_d    = tune_m;
                  cap_s_d    = tune_s;
                  cap_gain_d = gain_in;
               end else begin
                  ready_d = 1'b1;
               end
            end
            UPD_L: begin
               l_d    = enc5(cap_l);
               gain_d = cap_gain;
            end
            UPD_M:   m_d = enc16(cap_m);
            UPD_S: begin
               s_d     = enc16(cap_s);
               done_d  = 1'b1;
               ready_d = 1'b1;
            end
            default: ready_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_l    <= 5'(INIT_L);
         cap_m    <= 8'(INIT_M);
         cap_s    <= 8'(INIT_S);
         cap_gain <= 2'b00;
         l_q      <= L_INIT;
         m_q      <= M_INIT;
         s_q      <= S_INIT;
         pd_q     <= 1'b1;
         gain_q   <= 2'b00;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         lsat_q   <= 1'b0;
      end else begin
         cap_l    <= cap_l_d;
         cap_m    <= cap_m_d;
         cap_s    <= cap_s_d;
         cap_gain <= cap_gain_d;
         l_q      <= l_d;
         m_q      <= m_d;
         s_q      <= s_d;
         pd_q     <= pd_d;
         gain_q   <= gain_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         lsat_q   <= lsat_d;
      end
   end

   assign tune_ready = ready_q;
   assign pd         = pd_q;
   assign osc_gain   = gain_q;
   assign upd_done   = done_q;
   assign l_sat      = lsat_q;
   assign c_l_rall   = l_q.rall;
   assign c_l_row    = l_q.row;
   assign c_l_col    = l_q.col;
   assign c_m_rall   = m_q.rall;
   assign c_m_row    = m_q.row;
   assign c_m_col    = m_q.col;
   assign c_s_rall   = s_q.rall;
   assign c_s_row    = s_q.row;
   assign c_s_col    = s_q.col;

endmodule

// File: tb/tb_dco_ctr.sv
// Bench for dco_ctr: age-based reference model checked every cycle plus directed literal checks.
module tb_dco_ctr;

   localparam int PWR = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [4:0]  tune_l = '0;
   logic [7:0]  tune_m = '0;
   logic [7:0]  tune_s = '0;
   logic [1:0]  gain_in = '0;
   logic        tune_valid = 1'b0;
   logic        tune_ready, pd, upd_done, l_sat;
   logic [1:0]  osc_gain;
   logic [4:0]  c_l_rall, c_l_row, c_l_col;
   logic [15:0] c_m_rall, c_m_row, c_m_col, c_s_rall, c_s_row, c_s_col;

   int total = 0;
   int bad = 0;

   dco_ctr dut (
      .clk(clk), .rst_n(rst_n), .en(en), .tune_l(tune_l), .tune_m(tune_m), .tune_s(tune_s),
      .gain_in(gain_in), .tune_valid(tune_valid), .tune_ready(tune_ready), .pd(pd),
      .osc_gain(osc_gain), .c_l_rall(c_l_rall), .c_l_row(c_l_row), .c_l_col(c_l_col),
      .c_m_rall(c_m_rall), .c_m_row(c_m_row), .c_m_col(c_m_col),
      .c_s_rall(c_s_rall), .c_s_row(c_s_row), .c_s_col(c_s_col),
      .upd_done(upd_done), .l_sat(l_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: {rall,row,col} for code v in a bank of n rows.
   function automatic logic [47:0] menc(input int v, input int n);
      int q, r;
      logic [15:0] ra, ro, co;
      q  = v / n;
      r  = v % n;
      ra = 16'((1 << q) - 1);
      ro = (q < n) ? 16'(1 << q) : 16'd0;
      co = 16'((1 << r) - 1);
      return {ra, ro, co};
   endfunction

   function automatic int cells(input logic [15:0] ra, input logic [15:0] ro,
                                input logic [15:0] co, input int n);
      int c = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            if (ra[i] || (ro[i] && co[j])) c++;
      return c;
   endfunction

   // Model: en_age = edges since enable came up, upd_age = edges since capture (-1: none pending).
   int   en_age = 0, upd_age = -1;
   int   e_l = 12, e_m = 128, e_s = 128, p_l, p_m, p_s, p_g;
   logic e_pd = 1'b1, e_ready = 1'b0, e_done = 1'b0, e_lsat = 1'b0;
   logic [1:0] e_gain = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || !en) begin
         en_age = 0; upd_age = -1;
         e_pd = 1'b1; e_gain = 2'b00; e_ready = 1'b0; e_done = 1'b0;
         e_l = 12; e_m = 128; e_s = 128;
         if (!rst_n) e_lsat = 1'b0;
      end else begin
         logic cap;
         cap = e_ready && tune_valid;
         en_age++;
         e_done = 1'b0;
         if (upd_age >= 0) begin
            upd_age++;
            if (upd_age == 1) begin e_l = p_l; e_gain = 2'(p_g); end
            if (upd_age == 2) e_m = p_m;
            if (upd_age == 3) begin e_s = p_s; e_done = 1'b1; upd_age = -1; end
         end
         if (cap) begin
            p_l = (tune_l > 25) ? 25 : int'(tune_l);
            p_m = int'(tune_m); p_s = int'(tune_s); p_g = int'(gain_in);
            e_lsat = (tune_l > 25);
            upd_age = 0;
         end
         e_pd = 1'b0;
         if (en_age == 1) e_gain = 2'b11;
         e_ready = (en_age > PWR) && (upd_age < 0);
      end
   end

   always @(negedge clk) begin
      logic [47:0] el, em, es;
      el = menc(e_l, 5); em = menc(e_m, 16); es = menc(e_s, 16);
      chk("m_pd", 16'(pd), 16'(e_pd));
      chk("m_gain", 16'(osc_gain), 16'(e_gain));
      chk("m_ready", 16'(tune_ready), 16'(e_ready));
      chk("m_done", 16'(upd_done), 16'(e_done));
      chk("m_lsat", 16'(l_sat), 16'(e_lsat));
      chk("m_l", {1'b0, c_l_rall, c_l_row, c_l_col}, {1'b0, el[36:32], el[20:16], el[4:0]});
      chk("m_m_rall", c_m_rall, em[47:32]);
      chk("m_m_row", c_m_row, em[31:16]);
      chk("m_m_col", c_m_col, em[15:0]);
      chk("m_s_rall", c_s_rall, es[47:32]);
      chk("m_s_row", c_s_row, es[31:16]);
      chk("m_s_col", c_s_col, es[15:0]);
   end

   task automatic wait_ready();
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (tune_ready) break;
      end
      chk("wait_ready", 16'(tune_ready), 16'd1);
   endtask

   // Returns at the negedge after the handshake edge.
   task automatic send(input int l, input int m, input int s, input int g);
      wait_ready();
      tune_l = 5'(l); tune_m = 8'(m); tune_s = 8'(s); gain_in = 2'(g);
      tune_valid = 1'b1;
      @(negedge clk);
      tune_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (3) @(negedge clk);
      chk("rst_pd", 16'(pd), 16'd1);
      chk("rst_ready", 16'(tune_ready), 16'd0);
      chk("rst_m_rall", c_m_rall, 16'h00FF);
      chk("rst_m_row", c_m_row, 16'h0100);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // power-up, with an enable glitch that restarts it
      en = 1'b1;
      @(negedge clk);
      chk("pd_fall", 16'(pd), 16'd0);
      repeat (4) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("pd_glitch", 16'(pd), 16'd1);
      en = 1'b1;
      @(negedge clk);
      chk("pd_fall2", 16'(pd), 16'd0);
      c = 0;
      for (int i = 0; i < 64; i++) begin
         if (tune_ready) break;
         @(negedge clk);
         c++;
      end
      chk("pwrup_cycles", 16'(c), 16'd16);
      chk("pwrup_m_rall", c_m_rall, 16'h00FF);
      chk("pwrup_gain", 16'(osc_gain), 16'd3);

      // basic word
      send(7, 8'h5A, 8'hFF, 2);
      @(negedge clk);
      chk("l_rall", 16'(c_l_rall), 16'h01);
      chk("l_row", 16'(c_l_row), 16'h02);
      chk("l_col", 16'(c_l_col), 16'h03);
      chk("gain2", 16'(osc_gain), 16'd2);
      @(negedge clk);
      chk("m_rall", c_m_rall, 16'h001F);
      chk("m_row", c_m_row, 16'h0020);
      chk("m_col", c_m_col, 16'h03FF);
      @(negedge clk);
      chk("s_rall", c_s_rall, 16'h7FFF);
      chk("s_row", c_s_row, 16'h8000);
      chk("s_col", c_s_col, 16'h7FFF);
      chk("done", 16'(upd_done), 16'd1);
      @(negedge clk);
      chk("done_pulse", 16'(upd_done), 16'd0);
      chk("ready_back", 16'(tune_ready), 16'd1);

      // L saturation
      send(31, 1, 2, 1);
      repeat (3) @(negedge clk);
      chk("sat_rall", 16'(c_l_rall), 16'h1F);
      chk("sat_row", 16'(c_l_row), 16'h00);
      chk("sat_col", 16'(c_l_col), 16'h00);
      chk("sat_flag", 16'(l_sat), 16'd1);
      send(3, 1, 2, 1);
      chk("sat_clear", 16'(l_sat), 16'd0);

      // valid held high: only every 4th word is taken
      wait_ready();
      c = 0;
      for (int j = 0; j < 20; j++) begin
         tune_l = '0; tune_m = 8'(j); tune_s = 8'(j); gain_in = '0; tune_valid = 1'b1;
         @(negedge clk);
         if (upd_done) c++;
      end
      tune_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (upd_done) c++;
      end
      chk("stream_count", 16'(c), 16'd5);
      chk("stream_m_rall", c_m_rall, 16'h0001);
      chk("stream_m_row", c_m_row, 16'h0002);
      chk("stream_s_col", c_s_col, 16'h0000);

      // enable dropped while M is being applied
      send(7, 8'h5A, 8'hFF, 2);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("off_pd", 16'(pd), 16'd1);
      chk("off_gain", 16'(osc_gain), 16'd0);
      chk("off_ready", 16'(tune_ready), 16'd0);
      chk("off_done", 16'(upd_done), 16'd0);
      chk("off_l", {1'b0, c_l_rall, c_l_row, c_l_col}, {1'b0, 5'h03, 5'h04, 5'h03});
      chk("off_m_rall", c_m_rall, 16'h00FF);
      chk("off_m_row", c_m_row, 16'h0100);
      chk("off_s_col", c_s_col, 16'h0000);
      @(negedge clk);
      chk("off_done2", 16'(upd_done), 16'd0);
      en = 1'b1;

      // code sweep: cell count must equal the applied code
      for (int v = 0; v < 256; v++) begin
         send(v % 26, v, 255 - v, v % 4);
         repeat (3) @(negedge clk);
         chk("sweep_done", 16'(upd_done), 16'd1);
         chk("cells_l", 16'(cells({11'b0, c_l_rall}, {11'b0, c_l_row}, {11'b0, c_l_col}, 5)), 16'(v % 26));
         chk("cells_m", 16'(cells(c_m_rall, c_m_row, c_m_col, 16)), 16'(v));
         chk("cells_s", 16'(cells(c_s_rall, c_s_row, c_s_col, 16)), 16'(255 - v));
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
